// File: rtl/gcd_pkg.sv
// Shared definitions for the parametrised GCD engine.
//   state_t     : controller state encoding (IDLE / CALC / DONE)
//   MODE_*      : algorithm select values for the MODE parameter
package gcd_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam int MODE_EUCLID = 0;
   localparam int MODE_STEIN  = 1;

endpackage

// File: rtl/gcd_step.sv
// One GCD iteration, purely combinational.
//   a_i, b_i, k_i : current operands and common power-of-two count
//   a_o, b_o, k_o : operands and count after this iteration
//   term_o        : operands have converged; res_o carries the gcd
//   res_o         : final result (already re-scaled by 2^k)
// MODE selects subtractive Euclid (0) or binary Stein (1).
module gcd_step
   import gcd_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int MODE  = MODE_EUCLID,
   parameter int KW    = $clog2(WIDTH) + 1
) (
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic [KW-1:0]    k_i,
   output logic [WIDTH-1:0] a_o,
   output logic [WIDTH-1:0] b_o,
   output logic [KW-1:0]    k_o,
   output logic             term_o,
   output logic [WIDTH-1:0] res_o
);

   always_comb begin
      a_o    = a_i;
      b_o    = b_i;
      k_o    = k_i;
      term_o = 1'b0;
      res_o  = '0;
      if (a_i == '0) begin
         term_o = 1'b1;
         res_o  = b_i << k_i;
      end else if ((b_i == '0) || (a_i == b_i)) begin
         term_o = 1'b1;
         res_o  = a_i << k_i;
      end else if (MODE == MODE_EUCLID) begin
         if (a_i < b_i) b_o = b_i - a_i;
         else           a_o = a_i - b_i;
      end else begin
         // Common factors of two are stripped together and counted in k,
         // then restored by the final shift.
         if (!a_i[0] && !b_i[0]) begin
            a_o = a_i >> 1;
            b_o = b_i >> 1;
            k_o = k_i + KW'(1);
         end else if (!a_i[0]) begin
            a_o = a_i >> 1;
         end else if (!b_i[0]) begin
            b_o = b_i >> 1;
         end else if (a_i > b_i) begin
            a_o = a_i - b_i;
         end else begin
            b_o = b_i - a_i;
         end
      end
   end

endmodule

// File: rtl/gcd_engine_param.sv
// Parametrised GCD engine: controller, operand registers, iteration
// counter and valid/ready handshakes.
//   clk, rst_n            : clock, async active-low reset
//   in_valid/in_ready     : operand handshake (accepted only in IDLE)
//   a_in, b_in            : operands
//   abort                 : drop the current computation/result
//   out_valid/out_ready   : result handshake (held in DONE)
//   gcd_out, cycles_out   : result and saturating CALC cycle count
//
// state | meaning
// IDLE  | waiting for operands, in_ready=1
// CALC  | one gcd_step iteration per cycle
// DONE  | result presented, out_valid=1, held until out_ready
module gcd_engine_param
   import gcd_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int MODE  = MODE_EUCLID,
   parameter int CYC_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   input  logic             abort,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] gcd_out,
   output logic [CYC_W-1:0] cycles_out
);

   localparam int KW = $clog2(WIDTH) + 1;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, b_q, gcd_q;
   logic [KW-1:0]    k_q;
   logic [CYC_W-1:0] cnt_q, cyc_q, cnt_inc;

   logic [WIDTH-1:0] a_nxt, b_nxt, res;
   logic [KW-1:0]    k_nxt;
   logic             term;

   gcd_step #(
      .WIDTH (WIDTH),
      .MODE  (MODE),
      .KW    (KW)
   ) u_step (
      .a_i    (a_q),
      .b_i    (b_q),
      .k_i    (k_q),
      .a_o    (a_nxt),
      .b_o    (b_nxt),
      .k_o    (k_nxt),
      .term_o (term),
      .res_o  (res)
   );

   assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + CYC_W'(1);

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (in_valid) state_d = ST_CALC;
         ST_CALC: begin
            if (abort)     state_d = ST_IDLE;
            else if (term) state_d = ST_DONE;
         end
         ST_DONE: begin
            if (abort || out_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q   <= '0;
         b_q   <= '0;
         k_q   <= '0;
         cnt_q <= '0;
         gcd_q <= '0;
         cyc_q <= '0;
      end else if ((state_q == ST_IDLE) && in_valid) begin
         a_q   <= a_in;
         b_q   <= b_in;
         k_q   <= '0;
         cnt_q <= '0;
      end else if ((state_q == ST_CALC) && !abort) begin
         a_q   <= a_nxt;
         b_q   <= b_nxt;
         k_q   <= k_nxt;
         cnt_q <= cnt_inc;
         if (term) begin
            gcd_q <= res;
            cyc_q <= cnt_inc;
         end
      end
   end

   assign in_ready   = (state_q == ST_IDLE);
   assign out_valid  = (state_q == ST_DONE);
   assign gcd_out    = gcd_q;
   assign cycles_out = cyc_q;

endmodule

// File: tb/tb_gcd_engine_param.sv
module tb_gcd_engine_param;

   typedef struct {
      int u;
      int g;
      int c;
      int lat;
      int acc;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        iv[3];
   logic        ordy[3];
   logic        abrt[3];
   logic [15:0] a_s[3];
   logic [15:0] b_s[3];
   logic        ir[3];
   logic        ov[3];
   logic [15:0] g_s[3];
   logic [15:0] c_s[3];
   logic        prev_ov[3];

   logic [7:0]  g0, g1;
   logic [15:0] g2;
   logic [15:0] c0, c1;
   logic [7:0]  c2;

   exp_t sb[$];
   int   total = 0;
   int   bad = 0;
   int   cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   gcd_engine_param #(.WIDTH(8), .MODE(0), .CYC_W(16)) u0 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]),
      .a_in(a_s[0][7:0]), .b_in(b_s[0][7:0]), .abort(abrt[0]),
      .out_valid(ov[0]), .out_ready(ordy[0]), .gcd_out(g0), .cycles_out(c0));

   gcd_engine_param #(.WIDTH(8), .MODE(1), .CYC_W(16)) u1 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]),
      .a_in(a_s[1][7:0]), .b_in(b_s[1][7:0]), .abort(abrt[1]),
      .out_valid(ov[1]), .out_ready(ordy[1]), .gcd_out(g1), .cycles_out(c1));

   gcd_engine_param #(.WIDTH(16), .MODE(0), .CYC_W(8)) u2 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]),
      .a_in(a_s[2]), .b_in(b_s[2]), .abort(abrt[2]),
      .out_valid(ov[2]), .out_ready(ordy[2]), .gcd_out(g2), .cycles_out(c2));

   assign g_s[0] = {8'h00, g0};
   assign g_s[1] = {8'h00, g1};
   assign g_s[2] = g2;
   assign c_s[0] = c0;
   assign c_s[1] = c1;
   assign c_s[2] = {8'h00, c2};

   task automatic check(string name, int act, int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: every cycle a result is presented it is checked against the
   // scoreboard head; the entry is retired on the handshake.
   always @(negedge clk) begin
      for (int u = 0; u < 3; u++) begin
         if (rst_n && ov[u]) begin
            if (sb.size() == 0 || sb[0].u != u) begin
               total++;
               bad++;
               $display("FAIL unexpected_result: unit %0d presented gcd %0d, none expected", u, g_s[u]);
            end else begin
               if (!prev_ov[u]) check($sformatf("latency_u%0d", u), cyc - sb[0].acc, sb[0].lat);
               check($sformatf("gcd_u%0d", u), int'(g_s[u]), sb[0].g);
               check($sformatf("cycles_u%0d", u), int'(c_s[u]), sb[0].c);
               check($sformatf("in_ready_in_done_u%0d", u), int'(ir[u]), 0);
               if (ordy[u]) void'(sb.pop_front());
            end
         end
         prev_ov[u] = ov[u];
      end
   end

   task automatic send(int u, logic [15:0] a, logic [15:0] b, int g, int c, int lat, bit push);
      int n = 0;
      while (!ir[u] && n < 1000) begin
         @(posedge clk); #1;
         n++;
      end
      if (!ir[u]) begin
         total++;
         bad++;
         $display("FAIL send_timeout: unit %0d in_ready stuck at 0", u);
         return;
      end
      a_s[u] = a;
      b_s[u] = b;
      iv[u]  = 1'b1;
      @(posedge clk); #1;
      iv[u]  = 1'b0;
      if (push) sb.push_back('{u: u, g: g, c: c, lat: lat, acc: cyc});
   endtask

   task automatic drain();
      int n = 0;
      while (sb.size() != 0 && n < 70000) begin
         @(posedge clk); #1;
         n++;
      end
      if (sb.size() != 0) begin
         total++;
         bad++;
         $display("FAIL drain_timeout: %0d results still pending", sb.size());
         sb.delete();
      end
      @(posedge clk); #1;
   endtask

   task automatic backpressure(int u, int c1st, int c2nd);
      int n = 0;
      ordy[u] = 1'b0;
      send(u, 16'd12, 16'd8, 4, c1st, c1st, 1'b1);
      while (!ov[u] && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      check($sformatf("bp_out_valid_u%0d", u), int'(ov[u]), 1);
      repeat (10) @(posedge clk);
      #1;
      ordy[u] = 1'b1;
      @(posedge clk); #1;
      check($sformatf("bp_idle_after_handshake_u%0d", u), int'(ir[u]), 1);
      check($sformatf("bp_retired_u%0d", u), sb.size(), 0);
      send(u, 16'd9, 16'd6, 3, c2nd, c2nd, 1'b1);
      drain();
   endtask

   typedef struct {
      int u;
      int a;
      int b;
      int g;
      int c;
      int lat;
   } vec_t;

   vec_t vecs[] = '{
      '{0, 48, 18,  6, 5, 5},
      '{0,  0,  0,  0, 1, 1},
      '{0,  0, 35, 35, 1, 1},
      '{0, 35,  0, 35, 1, 1},
      '{0,  7,  7,  7, 1, 1},
      '{1, 48, 18,  6, 7, 7},
      '{1,  0,  0,  0, 1, 1},
      '{1,  0, 35, 35, 1, 1},
      '{1, 35,  0, 35, 1, 1},
      '{1,  7,  7,  7, 1, 1},
      '{1, 10,  4,  2, 6, 6}
   };

   initial begin
      for (int u = 0; u < 3; u++) begin
         iv[u] = 1'b0; ordy[u] = 1'b1; abrt[u] = 1'b0;
         a_s[u] = '0; b_s[u] = '0; prev_ov[u] = 1'b0;
      end
      repeat (3) @(posedge clk);
      #1;
      for (int u = 0; u < 3; u++) begin
         check($sformatf("reset_in_ready_u%0d", u), int'(ir[u]), 1);
         check($sformatf("reset_out_valid_u%0d", u), int'(ov[u]), 0);
         check($sformatf("reset_gcd_u%0d", u), int'(g_s[u]), 0);
         check($sformatf("reset_cycles_u%0d", u), int'(c_s[u]), 0);
      end
      rst_n = 1'b1;
      @(posedge clk); #1;

      foreach (vecs[i]) begin
         send(vecs[i].u, 16'(vecs[i].a), 16'(vecs[i].b), vecs[i].g, vecs[i].c, vecs[i].lat, 1'b1);
         drain();
      end

      backpressure(0, 3, 3);
      backpressure(1, 6, 4);

      // abort sampled at the third CALC edge of a 5-cycle computation
      send(0, 16'd48, 16'd18, 0, 0, 0, 1'b0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      abrt[0] = 1'b1;
      @(posedge clk); #1;
      abrt[0] = 1'b0;
      check("abort_out_valid", int'(ov[0]), 0);
      check("abort_in_ready", int'(ir[0]), 1);
      repeat (5) @(posedge clk);
      #1;
      check("abort_no_late_result", int'(ov[0]), 0);
      send(0, 16'd10, 16'd4, 2, 4, 4, 1'b1);
      drain();

      // reset in the middle of CALC
      send(0, 16'd48, 16'd18, 0, 0, 0, 1'b0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      check("rst_mid_gcd", int'(g_s[0]), 0);
      check("rst_mid_cycles", int'(c_s[0]), 0);
      check("rst_mid_out_valid", int'(ov[0]), 0);
      check("rst_mid_in_ready", int'(ir[0]), 1);
      #2;
      rst_n = 1'b1;
      @(posedge clk); #1;
      send(0, 16'd48, 16'd18, 6, 5, 5, 1'b1);
      drain();

      // counter saturation: 65535 CALC cycles, 8-bit count
      send(2, 16'd65535, 16'd1, 1, 255, 65535, 1'b1);
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/gcd_engine_param.md
Name: gcd_engine_param

Overview:
Self-contained, parametrised GCD engine: merges the controller and A/B datapath of the first-generation GCD unit into one block. Generalises the first generation with selectable operand width, a selectable algorithm (subtractive Euclid or binary Stein), valid/ready handshakes on input and output, zero-operand handling, an abort, and an iteration counter. Sits between a command source and a result consumer in the arithmetic subsystem.

Parameters:
WIDTH, 16, operand and result width in bits (>=2)
MODE, 0, 0 = subtractive Euclid, 1 = binary Stein
CYC_W, 16, width of the iteration counter output; counter saturates at all-ones

Ports:
clk  input  1  single clock, rising-edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operands a_in/b_in valid
in_ready  output  1  engine can accept operands
a_in  input  WIDTH  operand A
b_in  input  WIDTH  operand B
abort  input  1  synchronous abort of the current computation
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
gcd_out  output  WIDTH  gcd(A,B)
cycles_out  output  CYC_W  number of CALC cycles used, saturating

Behaviour:
- Reset (async, rst_n=0): state IDLE; A, B, shift count k, cycle count cleared to 0; in_ready=1, out_valid=0, gcd_out=0, cycles_out=0. Reset mid-computation discards all work.
- States: IDLE, CALC, DONE.
- IDLE: in_ready=1. At an edge with in_valid=1: A<=a_in, B<=b_in, k<=0, cnt<=0, go to CALC. in_ready=0 in CALC and DONE.
- CALC: one step per cycle, cnt<=cnt+1 (saturating) every CALC cycle, including the terminating one.
  - Termination, checked first in both modes: A==0 -> result B<<k; B==0 -> result A<<k; A==B -> result A<<k. Latch gcd_out and cycles_out (the value including this cycle), go to DONE.
  - MODE 0: A<B -> B<=B-A; else A<=A-B.
  - MODE 1, priority order: A and B even -> both >>1, k<=k+1; A even -> A>>=1; B even -> B>>=1; both odd -> the larger operand <= larger-smaller.
  - All arithmetic is unsigned, WIDTH bits; subtraction never underflows (larger minus smaller). k is clog2(WIDTH)+1 bits; the final shift cannot overflow WIDTH.
- DONE: out_valid=1. gcd_out and cycles_out are held stable until out_ready=1 at an edge, then the engine goes to IDLE. The next input is accepted no earlier than the following edge, so input and output never overlap.
- abort=1 in CALC or DONE: go to IDLE at the next edge, out_valid=0, and no result is delivered. abort has priority over the termination check and over the out_ready handshake. abort is ignored in IDLE.
- Latency: out_valid rises N edges after the acceptance edge, where N = cycles_out. MODE 0 worst case is about 2^WIDTH cycles; MODE 1 is at most about 2*WIDTH cycles.
- gcd(0,0)=0 with cycles_out=1.

Decomposition:
- Package gcd_pkg: state encoding constants (IDLE/CALC/DONE), MODE_EUCLID=0, MODE_STEIN=1.
- One sub-module, gcd_step: combinational next-A/next-B/next-k/terminate logic for one iteration, parametrised by WIDTH and MODE.
- The top level holds the FSM, the registers, the counter and the handshakes.

Test Plan:
1. MODE=0, WIDTH=8: a=48, b=18 -> gcd_out=6, cycles_out=5; out_valid rises 5 edges after acceptance.
2. MODE=1, WIDTH=8: a=48, b=18 -> gcd_out=6, cycles_out=7 (trace (24,9,k1),(12,9),(6,9),(3,9),(3,6),(3,3), then terminate).
3. Zero operands, both modes: (0,0) -> 0, cycles_out=1; (0,35) -> 35; (35,0) -> 35; (7,7) -> 7, cycles_out=1.
4. Backpressure: result (12,8) -> 4 with out_ready=0 for 10 cycles -> gcd_out/cycles_out stable, in_ready=0 throughout. Then out_ready=1 -> IDLE, and new operands (9,6) -> 3 are accepted the next cycle.
5. Abort and reset: abort in the 3rd CALC cycle of (48,18) -> IDLE, no out_valid pulse, next request (10,4) -> 2 correct. rst_n low mid-CALC -> all outputs 0 immediately.
6. MODE=0, WIDTH=16, CYC_W=8: a=65535, b=1 -> gcd_out=1, cycles_out=255 (saturated).
